// File: rtl/saturate_narrow_pkg.sv
// Shared definitions for the saturate_narrow width-reduction block:
// default lane geometry, the clamp-select encoding and a lane popcount.
package saturate_narrow_pkg;

    localparam int DATA_WIDTH_IN_DEF  = 32;
    localparam int DATA_WIDTH_OUT_DEF = 16;
    localparam int DEPTH_DEF          = 2;
    localparam int CNT_WIDTH_DEF      = 16;

    // Upper bound on lanes handled by popcount; DEPTH must not exceed it.
    localparam int MAX_LANES = 32;
    localparam int POP_WIDTH = $clog2(MAX_LANES + 1);

    typedef enum logic [1:0] {
        PASS      = 2'd0,
        CLAMP_MAX = 2'd1,
        CLAMP_MIN = 2'd2
    } clamp_sel_e;

    function automatic logic [POP_WIDTH-1:0] popcount(input logic [MAX_LANES-1:0] bits);
        logic [POP_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + POP_WIDTH'(bits[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/saturate_narrow_sat_lane.sv
// Overflow detection and clamp selection for one lane. Only the lane bits from
// the output sign position upward matter, so only that slice is passed in.
module sat_lane
    import saturate_narrow_pkg::*;
#(
    parameter int IN_W  = DATA_WIDTH_IN_DEF,
    parameter int OUT_W = DATA_WIDTH_OUT_DEF
) (
    input  logic [IN_W-OUT_W:0] value,
    input  logic                is_signed,
    output clamp_sel_e          sel,
    output logic                ovf
);

    // value[0] is lane bit OUT_W-1; value[IN_W-OUT_W] is the lane sign bit.
    always_comb begin
        sel = PASS;
        ovf = 1'b0;
        if (is_signed) begin
            if (!((&value) || !(|value))) begin
                ovf = 1'b1;
                sel = value[IN_W-OUT_W] ? CLAMP_MIN : CLAMP_MAX;
            end
        end else if (|value[IN_W-OUT_W:1]) begin
            ovf = 1'b1;
            sel = CLAMP_MAX;
        end
    end

endmodule

// File: rtl/saturate_narrow.sv
// Two-stage valid/ready pipeline narrowing DEPTH packed lanes with signed or
// unsigned saturation, per-lane overflow flags and saturation statistics.
module saturate_narrow
    import saturate_narrow_pkg::*;
#(
    parameter int DATA_WIDTH_IN  = DATA_WIDTH_IN_DEF,
    parameter int DATA_WIDTH_OUT = DATA_WIDTH_OUT_DEF,
    parameter int DEPTH          = DEPTH_DEF,
    parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en_n,
    input  logic                             IsSigned,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH_IN*DEPTH-1:0]   dataIn,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH_OUT*DEPTH-1:0]  dataOut,
    output logic [DEPTH-1:0]                 ovf_lane,
    output logic [DEPTH-1:0]                 ovf_sticky,
    output logic [CNT_WIDTH-1:0]             sat_count,
    input  logic                             clr_stats
);

    localparam int IW = DATA_WIDTH_IN;
    localparam int OW = DATA_WIDTH_OUT;

    logic                 s1_valid_q, s1_valid_d;
    logic [IW*DEPTH-1:0]  s1_data_q, s1_data_d;
    logic                 s1_signed_q, s1_signed_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [OW*DEPTH-1:0]  s2_data_q, s2_data_d;
    logic [DEPTH-1:0]     s2_ovf_q, s2_ovf_d;
    logic [DEPTH-1:0]     sticky_q, sticky_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    logic                 active;
    logic                 s2_adv;
    logic                 s1_adv;
    logic                 s1_open;
    logic [DEPTH-1:0]     s1_ovf;
    clamp_sel_e           s1_sel [DEPTH];
    logic [OW*DEPTH-1:0]  narrowed;
    logic [CNT_WIDTH:0]   count_sum;

    assign active   = !en_n;
    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_adv;
    assign s1_open  = !s1_valid_q || s2_adv;
    assign in_ready = s1_open && active;

    assign out_valid  = s2_valid_q && active;
    assign dataOut    = s2_data_q;
    assign ovf_lane   = s2_ovf_q;
    assign ovf_sticky = sticky_q;
    assign sat_count  = count_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_lane
        sat_lane #(
            .IN_W  (IW),
            .OUT_W (OW)
        ) u_sat_lane (
            .value     (s1_data_q[IW*i+OW-1 +: IW-OW+1]),
            .is_signed (s1_signed_q),
            .sel       (s1_sel[i]),
            .ovf       (s1_ovf[i])
        );
    end

    // Signed max is 0111..1, unsigned max is all ones; min only arises when signed.
    always_comb begin
        narrowed = '0;
        for (int i = 0; i < DEPTH; i++) begin
            case (s1_sel[i])
                CLAMP_MAX: narrowed[OW*i +: OW] = s1_signed_q ? {1'b0, {(OW-1){1'b1}}} : {OW{1'b1}};
                CLAMP_MIN: narrowed[OW*i +: OW] = {1'b1, {(OW-1){1'b0}}};
                default:   narrowed[OW*i +: OW] = s1_data_q[IW*i +: OW];
            endcase
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_signed_d = s1_signed_q;
        s2_valid_d  = s2_valid_q;
        s2_data_d   = s2_data_q;
        s2_ovf_d    = s2_ovf_q;
        if (active) begin
            if (s2_adv) begin
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_d = narrowed;
                    s2_ovf_d  = s1_ovf;
                end
            end
            if (s1_open) begin
                s1_valid_d = in_valid;
                if (in_valid) begin
                    s1_data_d   = dataIn;
                    s1_signed_d = IsSigned;
                end
            end
        end
    end

    assign count_sum = {1'b0, count_q} + (CNT_WIDTH+1)'(popcount(MAX_LANES'(s1_ovf)));

    // A clear discards the events of the beat advancing in the same cycle.
    always_comb begin
        sticky_d = sticky_q;
        count_d  = count_q;
        if (active) begin
            if (clr_stats) begin
                sticky_d = '0;
                count_d  = '0;
            end else if (s1_adv) begin
                sticky_d = sticky_q | s1_ovf;
                count_d  = count_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : count_sum[CNT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_signed_q <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_ovf_q    <= '0;
            sticky_q    <= '0;
            count_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_signed_q <= s1_signed_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            s2_ovf_q    <= s2_ovf_d;
            sticky_q    <= sticky_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: tb/tb_saturate_narrow.sv
// Self-checking bench for saturate_narrow (IN=32, OUT=16, DEPTH=2) using a
// clamp-by-arithmetic reference model and per-scenario test tasks.
module tb_saturate_narrow;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_n = 1'b0;
    logic        IsSigned = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] dataIn = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] dataOut;
    logic [1:0]  ovf_lane;
    logic [1:0]  ovf_sticky;
    logic [15:0] sat_count;
    logic        clr_stats = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state: expected beats in order, and expected statistics.
    logic [31:0] exp_data_q[$];
    logic [1:0]  exp_ovf_q[$];
    logic [31:0] got_data_q[$];
    logic [1:0]  got_ovf_q[$];
    int          exp_count = 0;
    logic [1:0]  exp_sticky = 2'b00;
    logic        last_acc;

    saturate_narrow #(
        .DATA_WIDTH_IN  (32),
        .DATA_WIDTH_OUT (16),
        .DEPTH          (2),
        .CNT_WIDTH      (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en_n       (en_n),
        .IsSigned   (IsSigned),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dataIn     (dataIn),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dataOut    (dataOut),
        .ovf_lane   (ovf_lane),
        .ovf_sticky (ovf_sticky),
        .sat_count  (sat_count),
        .clr_stats  (clr_stats)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Clamp each lane to the representable output range using plain integers.
    function automatic void ref_beat(input logic [63:0] din, input logic sg,
                                     output logic [31:0] d, output logic [1:0] o);
        logic [31:0] lane;
        longint v, hi, lo;
        d = '0;
        o = '0;
        for (int i = 0; i < 2; i++) begin
            lane = din[32*i +: 32];
            if (sg) begin
                v  = longint'($signed(lane));
                hi = 32767;
                lo = -32768;
            end else begin
                v  = longint'({32'b0, lane});
                hi = 65535;
                lo = 0;
            end
            o[i] = (v > hi) || (v < lo);
            if (v > hi) v = hi;
            else if (v < lo) v = lo;
            d[16*i +: 16] = v[15:0];
        end
    endfunction

    function automatic logic [31:0] rand_lane();
        case ($urandom_range(0, 4))
            0:       return $urandom();
            1:       return 32'h0000_7FFE + $urandom_range(0, 2);
            2:       return 32'hFFFF_7FFF + $urandom_range(0, 2);
            3:       return 32'h0000_FFFE + $urandom_range(0, 2);
            default: return $urandom_range(0, 32'h0000_FFFF);
        endcase
    endfunction

    function automatic logic [63:0] rand_beat();
        return {rand_lane(), rand_lane()};
    endfunction

    // Drive one clock cycle, then record handshakes into the model/observed queues.
    task automatic cycle(input logic iv, input logic [63:0] din, input logic sg,
                         input logic ordy, input logic enn, input logic clr);
        logic [31:0] d;
        logic [1:0]  o;
        int          sum;
        in_valid  = iv;
        dataIn    = din;
        IsSigned  = sg;
        out_ready = ordy;
        en_n      = enn;
        clr_stats = clr;
        @(negedge clk);
        last_acc = iv && in_ready && !enn;
        if (clr && !enn) begin
            exp_count  = 0;
            exp_sticky = 2'b00;
        end
        if (last_acc) begin
            ref_beat(din, sg, d, o);
            exp_data_q.push_back(d);
            exp_ovf_q.push_back(o);
            exp_sticky = exp_sticky | o;
            sum = exp_count + $countones(o);
            exp_count = (sum > 65535) ? 65535 : sum;
        end
        if (out_valid && ordy && !enn) begin
            got_data_q.push_back(dataOut);
            got_ovf_q.push_back(ovf_lane);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        exp_data_q.delete();
        exp_ovf_q.delete();
        got_data_q.delete();
        got_ovf_q.delete();
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr_stats = 1'b0;
        en_n      = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        flush();
        exp_count  = 0;
        exp_sticky = 2'b00;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid);
        end
        tests_run++;
        if (dataOut !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_dataOut: got %h, expected 00000000", dataOut);
        end
        tests_run++;
        if (ovf_lane !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL reset_ovf_lane: got %b, expected 00", ovf_lane);
        end
        tests_run++;
        if (ovf_sticky !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL reset_ovf_sticky: got %b, expected 00", ovf_sticky);
        end
        tests_run++;
        if (sat_count !== 16'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_sat_count: got %h, expected 0000", sat_count);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
    endtask

    // Directed boundary vectors with hand-computed expectations.
    task automatic test_directed();
        logic [63:0] din_tab [3];
        logic        sg_tab  [3];
        logic [31:0] d_tab   [3];
        logic [1:0]  o_tab   [3];
        logic [15:0] c_tab   [3];
        logic [1:0]  s_tab   [3];
        din_tab[0] = {32'hFFFF_8000, 32'h0000_7FFF}; sg_tab[0] = 1'b1;
        d_tab[0] = 32'h8000_7FFF; o_tab[0] = 2'b00; c_tab[0] = 16'd0; s_tab[0] = 2'b00;
        din_tab[1] = {32'hFFFF_7FFF, 32'h0000_8000}; sg_tab[1] = 1'b1;
        d_tab[1] = 32'h8000_7FFF; o_tab[1] = 2'b11; c_tab[1] = 16'd2; s_tab[1] = 2'b11;
        din_tab[2] = {32'h0000_FFFF, 32'h0001_0000}; sg_tab[2] = 1'b0;
        d_tab[2] = 32'hFFFF_FFFF; o_tab[2] = 2'b01; c_tab[2] = 16'd3; s_tab[2] = 2'b11;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, din_tab[k], sg_tab[k], 1'b1, 1'b0, 1'b0);
            tests_run++;
            if (!last_acc || out_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL dir%0d_latency_early: accepted %b out_valid %b, expected 1 and 0", k, last_acc, out_valid);
            end
            cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
            tests_run++;
            if (out_valid !== 1'b1 || dataOut !== d_tab[k] || ovf_lane !== o_tab[k]) begin
                tests_failed++;
                $display("[TB] FAIL dir%0d_output: got valid %b data %h ovf %b, expected 1 %h %b",
                         k, out_valid, dataOut, ovf_lane, d_tab[k], o_tab[k]);
            end
            cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
            tests_run++;
            if (sat_count !== c_tab[k] || ovf_sticky !== s_tab[k]) begin
                tests_failed++;
                $display("[TB] FAIL dir%0d_stats: got count %0d sticky %b, expected %0d %b",
                         k, sat_count, ovf_sticky, c_tab[k], s_tab[k]);
            end
        end
        flush();
    endtask

    task automatic test_back_to_back();
        logic [63:0] beats [4];
        int          sent = 0;
        int          guard = 0;
        logic [31:0] snap;
        flush();
        for (int i = 0; i < 4; i++) beats[i] = rand_beat();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, beats[sent], 1'b1, 1'b0, 1'b0, 1'b0);
            if (last_acc) sent++;
            if (i == 1) snap = dataOut;
        end
        tests_run++;
        if (sent != 2 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stall_accepts: got %0d beats in_ready %b, expected 2 and 0", sent, in_ready);
        end
        tests_run++;
        if (dataOut !== snap || dataOut !== exp_data_q[0]) begin
            tests_failed++;
            $display("[TB] FAIL stall_hold: got %h, expected %h", dataOut, exp_data_q[0]);
        end
        while (got_data_q.size() < 4 && guard < 20) begin
            if (sent < 4) begin
                cycle(1'b1, beats[sent], 1'b1, 1'b1, 1'b0, 1'b0);
                if (last_acc) sent++;
            end else begin
                cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
            end
            guard++;
        end
        tests_run++;
        if (got_data_q.size() != 4 || exp_data_q.size() != 4) begin
            tests_failed++;
            $display("[TB] FAIL stall_beat_count: got %0d beats, expected 4", got_data_q.size());
        end
        for (int i = 0; i < exp_data_q.size() && i < got_data_q.size(); i++) begin
            tests_run++;
            if (got_data_q[i] !== exp_data_q[i] || got_ovf_q[i] !== exp_ovf_q[i]) begin
                tests_failed++;
                $display("[TB] FAIL stall_beat%0d: got %h/%b, expected %h/%b",
                         i, got_data_q[i], got_ovf_q[i], exp_data_q[i], exp_ovf_q[i]);
            end
        end
        flush();
    endtask

    task automatic test_enable();
        logic [31:0] snap_data;
        logic [15:0] snap_cnt;
        int          guard = 0;
        flush();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, rand_beat(), 1'($urandom_range(0, 1)), 1'b1, (i >= 3 && i <= 5), 1'b0);
            if (i == 2) begin
                snap_data = dataOut;
                snap_cnt  = sat_count;
            end
            if (i >= 3 && i <= 5) begin
                tests_run++;
                if (in_ready !== 1'b0 || out_valid !== 1'b0 || dataOut !== snap_data || sat_count !== snap_cnt) begin
                    tests_failed++;
                    $display("[TB] FAIL freeze%0d: got ready %b valid %b data %h count %0d, expected 0 0 %h %0d",
                             i, in_ready, out_valid, dataOut, sat_count, snap_data, snap_cnt);
                end
            end
        end
        while (got_data_q.size() < exp_data_q.size() && guard < 10) begin
            cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
            guard++;
        end
        tests_run++;
        if (got_data_q.size() != exp_data_q.size() || exp_data_q.size() != 7) begin
            tests_failed++;
            $display("[TB] FAIL freeze_beat_count: got %0d beats out of %0d accepted, expected 7",
                     got_data_q.size(), exp_data_q.size());
        end
        for (int i = 0; i < exp_data_q.size() && i < got_data_q.size(); i++) begin
            tests_run++;
            if (got_data_q[i] !== exp_data_q[i] || got_ovf_q[i] !== exp_ovf_q[i]) begin
                tests_failed++;
                $display("[TB] FAIL freeze_beat%0d: got %h/%b, expected %h/%b",
                         i, got_data_q[i], got_ovf_q[i], exp_data_q[i], exp_ovf_q[i]);
            end
        end
        tests_run++;
        if (sat_count !== 16'(exp_count) || ovf_sticky !== exp_sticky) begin
            tests_failed++;
            $display("[TB] FAIL freeze_stats: got %0d/%b, expected %0d/%b", sat_count, ovf_sticky, exp_count, exp_sticky);
        end
        flush();
    endtask

    task automatic test_clr_stats();
        flush();
        cycle(1'b1, {32'h0000_8000, 32'h0001_0000}, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (sat_count !== 16'h0 || ovf_sticky !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL clr_coincident: got %0d/%b, expected 0/00", sat_count, ovf_sticky);
        end
        tests_run++;
        if (got_data_q.size() != 1 || got_data_q[0] !== 32'h7FFF_7FFF || got_ovf_q[0] !== 2'b11) begin
            tests_failed++;
            $display("[TB] FAIL clr_data: got %0d beats first %h, expected 1 beat 7fff7fff/11",
                     got_data_q.size(), (got_data_q.size() > 0) ? got_data_q[0] : 32'h0);
        end
        cycle(1'b1, {32'h0000_0005, 32'hFFFF_0000}, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (sat_count !== 16'd1 || ovf_sticky !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL clr_after: got %0d/%b, expected 1/01", sat_count, ovf_sticky);
        end
        flush();
    endtask

    task automatic test_random();
        flush();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) < 7), rand_beat(), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0), 1'b0);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (got_data_q.size() != exp_data_q.size()) begin
            tests_failed++;
            $display("[TB] FAIL rand_beat_count: got %0d beats, expected %0d", got_data_q.size(), exp_data_q.size());
        end
        for (int i = 0; i < exp_data_q.size() && i < got_data_q.size(); i++) begin
            tests_run++;
            if (got_data_q[i] !== exp_data_q[i] || got_ovf_q[i] !== exp_ovf_q[i]) begin
                tests_failed++;
                $display("[TB] FAIL rand_beat%0d: got %h/%b, expected %h/%b",
                         i, got_data_q[i], got_ovf_q[i], exp_data_q[i], exp_ovf_q[i]);
            end
        end
        tests_run++;
        if (sat_count !== 16'(exp_count) || ovf_sticky !== exp_sticky) begin
            tests_failed++;
            $display("[TB] FAIL rand_stats: got %0d/%b, expected %0d/%b", sat_count, ovf_sticky, exp_count, exp_sticky);
        end
        flush();
    endtask

    task automatic test_reset_midstream();
        flush();
        cycle(1'b1, {32'h8000_0000, 32'h7000_0000}, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, {32'h0002_0000, 32'h0003_0000}, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || sat_count !== 16'h0 || ovf_sticky !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL midreset_state: got valid %b count %0d sticky %b, expected 0 0 00",
                     out_valid, sat_count, ovf_sticky);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (got_data_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_drain: got %0d beats, expected 0", got_data_q.size());
        end
        flush();
        exp_count  = 0;
        exp_sticky = 2'b00;
    endtask

    task automatic test_sat_limit();
        logic [63:0] both_ovf;
        both_ovf = {32'h0001_0000, 32'h0001_0000};
        do_reset();
        for (int i = 0; i < 32767; i++) cycle(1'b1, both_ovf, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (sat_count !== 16'hFFFE) begin
            tests_failed++;
            $display("[TB] FAIL satcnt_near: got %h, expected fffe", sat_count);
        end
        cycle(1'b1, both_ovf, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (sat_count !== 16'hFFFF) begin
            tests_failed++;
            $display("[TB] FAIL satcnt_reach: got %h, expected ffff", sat_count);
        end
        cycle(1'b1, both_ovf, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (sat_count !== 16'hFFFF || ovf_sticky !== 2'b11) begin
            tests_failed++;
            $display("[TB] FAIL satcnt_hold: got %h/%b, expected ffff/11", sat_count, ovf_sticky);
        end
        flush();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_enable();
        test_clr_stats();
        test_random();
        test_reset_midstream();
        test_sat_limit();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
